fpu_issue_rob: RTL and testbench

FPU_ISSUE_ROB -- requirements
Module: fpu_issue_rob

---
 rtl/fpu_issue_rob.sv | 160 ++++++++++++++++
 tb/tb_fpu_issue_rob.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_issue_rob.sv
// fpu_issue_rob: issues FPU requests to one of N_UNITS in-order units and
// returns their results strictly in accept order through a small reorder buffer.
module fpu_issue_rob #(
    parameter int unsigned WIDTH   = 32,
    parameter int unsigned N_UNITS = 7,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TAG_W   = 4
) (
    input  logic                       aclk,
    input  logic                       aresetn,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [2:0]                 operator,
    input  logic [2:0]                 subop,
    input  logic [WIDTH-1:0]           a,
    input  logic [WIDTH-1:0]           b,
    input  logic [TAG_W-1:0]           tag_in,
    output logic [N_UNITS-1:0]         unit_valid,
    output logic [WIDTH-1:0]           unit_a,
    output logic [WIDTH-1:0]           unit_b,
    output logic [2:0]                 unit_subop,
    input  logic [N_UNITS-1:0]         unit_res_valid,
    input  logic [N_UNITS*WIDTH-1:0]   unit_res_data,
    output logic                       result_valid,
    input  logic                       result_ready,
    output logic [WIDTH-1:0]           c,
    output logic [TAG_W-1:0]           tag_out,
    output logic                       illegal_op,
    output logic                       spurious
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] done_q, done_d;
    logic [DEPTH-1:0] ill_q, ill_d;
    logic [2:0]       op_q   [DEPTH];
    logic [2:0]       op_d   [DEPTH];
    logic [TAG_W-1:0] tag_q  [DEPTH];
    logic [TAG_W-1:0] tag_d  [DEPTH];
    logic [WIDTH-1:0] data_q [DEPTH];
    logic [WIDTH-1:0] data_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             spurious_q, spurious_d;

    logic             accept, pop, legal, hit;
    logic [PTR_W-1:0] idx;

    assign in_ready   = 32'(count_q) < DEPTH;
    assign accept     = in_valid && in_ready;
    assign legal      = 32'(operator) < N_UNITS;
    assign unit_a     = a;
    assign unit_b     = b;
    assign unit_subop = subop;

    assign result_valid = valid_q[head_q] && done_q[head_q];
    assign pop          = result_valid && result_ready;
    assign c            = result_valid ? data_q[head_q] : '0;
    assign tag_out      = result_valid ? tag_q[head_q] : '0;
    assign illegal_op   = result_valid && ill_q[head_q];
    assign spurious     = spurious_q;

    // One-hot issue strobe for a legal accepted request.
    always_comb begin
        unit_valid = '0;
        for (int k = 0; k < int'(N_UNITS); k++) begin
            unit_valid[k] = accept && legal && (operator == 3'(k));
        end
    end

    // Next state: allocate at tail, capture unit results oldest-first, free head.
    always_comb begin
        valid_d    = valid_q;
        done_d     = done_q;
        ill_d      = ill_q;
        op_d       = op_q;
        tag_d      = tag_q;
        data_d     = data_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        spurious_d = spurious_q;
        hit        = 1'b0;
        idx        = '0;

        if (accept) begin
            valid_d[tail_q] = 1'b1;
            done_d[tail_q]  = !legal;
            ill_d[tail_q]   = !legal;
            op_d[tail_q]    = operator;
            tag_d[tail_q]   = tag_in;
            data_d[tail_q]  = '0;
            tail_d          = tail_q + 1'b1;
        end

        // The entry allocated this cycle sits at offset count from head, so it
        // is only reached when no older entry for the same unit is pending.
        for (int k = 0; k < int'(N_UNITS); k++) begin
            if (unit_res_valid[k]) begin
                hit = 1'b0;
                for (int i = 0; i < int'(DEPTH); i++) begin
                    idx = head_q + PTR_W'(i);
                    if (!hit && valid_d[idx] && !done_d[idx] && (op_d[idx] == 3'(k))) begin
                        hit         = 1'b1;
                        done_d[idx] = 1'b1;
                        data_d[idx] = unit_res_data[k*WIDTH +: WIDTH];
                    end
                end
                if (!hit) begin
                    spurious_d = 1'b1;
                end
            end
        end

        if (pop) begin
            valid_d[head_q] = 1'b0;
            head_d          = head_q + 1'b1;
        end

        unique case ({accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // State register with asynchronous clear of the whole buffer.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            valid_q    <= '0;
            done_q     <= '0;
            ill_q      <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            spurious_q <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                op_q[i]   <= '0;
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else begin
            valid_q    <= valid_d;
            done_q     <= done_d;
            ill_q      <= ill_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            spurious_q <= spurious_d;
            for (int i = 0; i < int'(DEPTH); i++) begin
                op_q[i]   <= op_d[i];
                tag_q[i]  <= tag_d[i];
                data_q[i] <= data_d[i];
            end
        end
    end

endmodule

// File: tb/tb_fpu_issue_rob.sv
// tb_fpu_issue_rob: directed stimulus with a scoreboard queue and an
// independent monitor checking results in accept order.
module tb_fpu_issue_rob;

    localparam int WIDTH = 32;
    localparam int NU    = 7;
    localparam int TW    = 4;

    logic              aclk, aresetn;
    logic              in_valid, in_ready;
    logic [2:0]        operator, subop;
    logic [WIDTH-1:0]  a, b;
    logic [TW-1:0]     tag_in;
    logic [NU-1:0]     unit_valid;
    logic [WIDTH-1:0]  unit_a, unit_b;
    logic [2:0]        unit_subop;
    logic [NU-1:0]     unit_res_valid;
    logic [NU*WIDTH-1:0] unit_res_data;
    logic              result_valid, result_ready;
    logic [WIDTH-1:0]  c;
    logic [TW-1:0]     tag_out;
    logic              illegal_op, spurious;

    typedef struct packed {
        logic [TW-1:0]    tag;
        logic [WIDTH-1:0] data;
        logic             ill;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;

    fpu_issue_rob dut (
        .aclk           (aclk),
        .aresetn        (aresetn),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .operator       (operator),
        .subop          (subop),
        .a              (a),
        .b              (b),
        .tag_in         (tag_in),
        .unit_valid     (unit_valid),
        .unit_a         (unit_a),
        .unit_b         (unit_b),
        .unit_subop     (unit_subop),
        .unit_res_valid (unit_res_valid),
        .unit_res_data  (unit_res_data),
        .result_valid   (result_valid),
        .result_ready   (result_ready),
        .c              (c),
        .tag_out        (tag_out),
        .illegal_op     (illegal_op),
        .spurious       (spurious)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Drive one request, wait (bounded) for acceptance, check issue strobe, push expectation.
    task automatic issue(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                         input logic [3:0] t, input logic [31:0] res);
        int n;
        logic [NU-1:0] uv_exp;
        in_valid = 1'b1;
        operator = op;
        subop    = op ^ 3'd5;
        a        = av;
        b        = bv;
        tag_in   = t;
        n = 0;
        while (!in_ready && n < 50) begin
            @(posedge aclk);
            #1;
            n++;
        end
        chk("accept_timeout", {63'b0, in_ready}, 64'd1);
        uv_exp = '0;
        if (op < 3'(NU)) uv_exp[op] = 1'b1;
        @(negedge aclk);
        chk("unit_valid", {57'b0, unit_valid}, {57'b0, uv_exp});
        chk("unit_a", {32'b0, unit_a}, {32'b0, av});
        chk("unit_subop", {61'b0, unit_subop}, {61'b0, op ^ 3'd5});
        q.push_back({t, (op < 3'(NU)) ? res : 32'h0, op >= 3'(NU)});
        @(posedge aclk);
        #1;
        in_valid = 1'b0;
    endtask

    // One-cycle result strobe from unit k.
    task automatic reply(input int k, input logic [31:0] d);
        unit_res_valid[k]          = 1'b1;
        unit_res_data[k*32 +: 32]  = d;
        @(posedge aclk);
        #1;
        unit_res_valid = '0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (q.size() != 0 && n < 40) begin
            @(negedge aclk);
            n++;
        end
        chk("drain", 64'(q.size()), 64'd0);
        @(posedge aclk);
        #1;
    endtask

    // Monitor: compare every delivered result against the scoreboard head.
    initial begin
        exp_t e;
        forever begin
            @(negedge aclk);
            if (aresetn && result_valid && result_ready) begin
                if (q.size() == 0) begin
                    chk("unexpected_result", 64'd1, 64'd0);
                end else begin
                    e = q.pop_front();
                    chk("c", {32'b0, c}, {32'b0, e.data});
                    chk("tag_out", {60'b0, tag_out}, {60'b0, e.tag});
                    chk("illegal_op", {63'b0, illegal_op}, {63'b0, e.ill});
                end
            end else if (aresetn && !result_valid) begin
                chk("c_idle_zero", {32'b0, c}, 64'd0);
            end
        end
    end

    initial begin
        aresetn        = 1'b0;
        in_valid       = 1'b0;
        operator       = '0;
        subop          = '0;
        a              = '0;
        b              = '0;
        tag_in         = '0;
        unit_res_valid = '0;
        unit_res_data  = '0;
        result_ready   = 1'b1;

        // Reset state
        @(negedge aclk);
        chk("rst_result_valid", {63'b0, result_valid}, 64'd0);
        chk("rst_c", {32'b0, c}, 64'd0);
        chk("rst_tag_out", {60'b0, tag_out}, 64'd0);
        chk("rst_illegal", {63'b0, illegal_op}, 64'd0);
        chk("rst_spurious", {63'b0, spurious}, 64'd0);
        chk("rst_in_ready", {63'b0, in_ready}, 64'd1);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;

        // Single op, unit 2 replies two cycles after accept -> valid 3 cycles after accept
        issue(3'd2, 32'h3f800000, 32'h40000000, 4'd5, 32'h40000000);
        @(negedge aclk);
        chk("single_lat_c1", {63'b0, result_valid}, 64'd0);
        @(posedge aclk);
        #1;
        reply(2, 32'h40000000);
        @(negedge aclk);
        chk("single_lat_c3", {63'b0, result_valid}, 64'd1);
        drain();

        // Illegal operator: done the cycle after accept
        issue(3'd7, 32'h1, 32'h2, 4'd9, 32'h0);
        @(negedge aclk);
        chk("illegal_valid", {63'b0, result_valid}, 64'd1);
        chk("illegal_flag", {63'b0, illegal_op}, 64'd1);
        drain();

        // Reorder: slow unit 4 first, fast unit 0 second
        issue(3'd4, 32'h10, 32'h11, 4'd1, 32'h11110004);
        issue(3'd0, 32'h20, 32'h21, 4'd2, 32'h22220000);
        reply(0, 32'h22220000);
        @(negedge aclk);
        chk("reorder_hold", {63'b0, result_valid}, 64'd0);
        repeat (6) @(posedge aclk);
        #1;
        reply(4, 32'h11110004);
        drain();

        // Same unit twice
        issue(3'd1, 32'h30, 32'h31, 4'd3, 32'hAAAA0001);
        issue(3'd1, 32'h40, 32'h41, 4'd4, 32'hAAAA0002);
        reply(1, 32'hAAAA0001);
        reply(1, 32'hAAAA0002);
        drain();

        // Two units reply in the same cycle
        issue(3'd5, 32'h50, 32'h51, 4'd6, 32'h55550005);
        issue(3'd6, 32'h60, 32'h61, 4'd7, 32'h66660006);
        unit_res_valid[5]         = 1'b1;
        unit_res_data[5*32 +: 32] = 32'h55550005;
        reply(6, 32'h66660006);
        drain();

        // Capture into an entry allocated in the same cycle
        unit_res_valid[3]         = 1'b1;
        unit_res_data[3*32 +: 32] = 32'h33330003;
        issue(3'd3, 32'h70, 32'h71, 4'd8, 32'h33330003);
        unit_res_valid = '0;
        drain();
        chk("no_spurious_yet", {63'b0, spurious}, 64'd0);

        // Full buffer: fifth request waits for the first pop, accepted the cycle after
        for (int i = 0; i < 4; i++) begin
            issue(3'd2, 32'h80 + i, 32'h90, 4'(10 + i), 32'h50000000 + i);
        end
        chk("full_in_ready", {63'b0, in_ready}, 64'd0);
        in_valid = 1'b1;
        operator = 3'd7;
        tag_in   = 4'd14;
        repeat (3) begin
            @(negedge aclk);
            chk("full_hold", {63'b0, in_ready}, 64'd0);
        end
        @(posedge aclk);
        #1;
        reply(2, 32'h50000000);
        q.push_back({4'd14, 32'h0, 1'b1});
        @(negedge aclk);
        chk("pop_cycle_in_ready", {63'b0, in_ready}, 64'd0);
        chk("pop_cycle_valid", {63'b0, result_valid}, 64'd1);
        @(posedge aclk);
        #1;
        @(negedge aclk);
        chk("after_pop_in_ready", {63'b0, in_ready}, 64'd1);
        @(posedge aclk);
        #1;
        in_valid = 1'b0;
        reply(2, 32'h50000001);
        reply(2, 32'h50000002);
        reply(2, 32'h50000003);
        drain();

        // Backpressure: head result held stable
        result_ready = 1'b0;
        issue(3'd0, 32'hA0, 32'hA1, 4'd12, 32'hDEADBEEF);
        reply(0, 32'hDEADBEEF);
        repeat (5) begin
            @(negedge aclk);
            chk("bp_valid", {63'b0, result_valid}, 64'd1);
            chk("bp_c", {32'b0, c}, {32'b0, 32'hDEADBEEF});
            chk("bp_tag", {60'b0, tag_out}, 64'd12);
        end
        @(posedge aclk);
        #1;
        result_ready = 1'b1;
        drain();

        // Spurious result is sticky
        chk("spurious_pre", {63'b0, spurious}, 64'd0);
        reply(3, 32'h1234);
        repeat (3) begin
            @(negedge aclk);
            chk("spurious_sticky", {63'b0, spurious}, 64'd1);
        end
        @(posedge aclk);
        #1;

        // Reset mid-operation discards the pending entry
        issue(3'd1, 32'hB0, 32'hB1, 4'd2, 32'h0BAD0001);
        aresetn = 1'b0;
        q.delete();
        @(negedge aclk);
        chk("mid_rst_spurious", {63'b0, spurious}, 64'd0);
        chk("mid_rst_valid", {63'b0, result_valid}, 64'd0);
        chk("mid_rst_in_ready", {63'b0, in_ready}, 64'd1);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
        @(posedge aclk);
        #1;
        reply(1, 32'h0BAD0001);
        @(negedge aclk);
        chk("post_rst_spurious", {63'b0, spurious}, 64'd1);
        chk("post_rst_valid", {63'b0, result_valid}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running want finished");
        $fatal(1);
    end

endmodule
